prog_loader: RTL and testbench

- Byte-stream program loader; the write-side counterpart of the CPU's instruction/data fetch from its 8-bit memory.
- Receives a framed byte stream over a valid/ready interface and writes the bytes into the CPU memory through a simple write port.
- Holds the CPU in reset while a load is in progress and releases it only after a frame whose checksum verifies.
- Sits between a host link (UART or bench) and the memory write port of cpu.

---
 rtl/prog_loader_if.sv | 19 +
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a host link and the program loader.
// The host side owns data/valid; the loader side owns ready.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, START_ADDR, COUNT, data..., CSUM.
// Writes the data into CPU memory and holds the CPU in reset until a frame verifies.
module prog_loader #(
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      in_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4
  } state_t;

  // Running checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                in_ready_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                accept_s;
  logic                timeout_s;

  assign accept_s  = in_if.in_valid && in_ready_q;
  assign timeout_s = (state_q != S_SYNC) && !accept_s && (idle_q == IDLE_LAST);

  // State, datapath and output registers; ready rises on the first edge out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SYNC;
      ptr_q       <= '0;
      cnt_q       <= 8'd0;
      sum_q       <= 8'd0;
      idle_q      <= IDLE_ZERO;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      in_ready_q  <= 1'b1;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Frame parser: next state, write strobe, status flags and mid-frame idle watchdog.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    idle_d      = idle_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    if (state_q == S_SYNC || accept_s) begin
      idle_d = IDLE_ZERO;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end

    if (timeout_s) begin
      state_d     = S_SYNC;
      load_err_d  = 1'b1;
      cpu_reset_d = 1'b1;
      idle_d      = IDLE_ZERO;
    end else if (accept_s) begin
      case (state_q)
        S_SYNC: begin
          // Anything but the marker is line noise and simply dropped.
          if (in_if.in_data == SYNC_BYTE) begin
            state_d     = S_ADDR;
            cpu_reset_d = 1'b1;
            load_err_d  = 1'b0;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_ADDR: begin
          ptr_d   = in_if.in_data[ADDR_W-1:0];
          sum_d   = in_if.in_data;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          cnt_d = in_if.in_data;
          sum_d = csum_add(sum_q, in_if.in_data);
          if (in_if.in_data == 8'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_if.in_data;
          ptr_d       = ptr_q + PTR_ONE;
          cnt_d       = cnt_q - 8'd1;
          sum_d       = csum_add(sum_q, in_if.in_data);
          if (cnt_q == 8'd1) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (in_if.in_data == sum_q) begin
            load_done_d = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            load_err_d  = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, wrap, bad checksum, timeout, gaps, reset mid-frame.
module tb_prog_loader;
  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       reset;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       load_done;
  logic       load_err;

  int checks;
  int errors;
  int done_cnt;
  logic [4:0] wa[$];
  logic [7:0] wd[$];

  prog_loader_if bus ();

  prog_loader #(.ADDR_W(5), .SYNC_BYTE(8'hA5), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #3;
    checks++;
    if ({bus.in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err} !== {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b want 0 0 00 00 1 0 0",
               bus.in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err);
    end
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_load_program();
    byte_q_t f;
    logic [7:0] ed[10] = '{8'h11, 8'h22, 8'h99, 8'h53, 8'h13, 8'hD9, 8'h99, 8'h53, 8'hC4, 8'hC9};
    f = '{8'hA5, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h99, 8'h53, 8'h13, 8'hD9, 8'h99, 8'h53, 8'hC4, 8'hC9};
    clear_mon();
    send_seq(f);
    checks++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL prog_before_csum got cr=%b dn=%b want 1 0", cpu_reset, load_done);
    end
    send(8'h8E);
    checks++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL prog_done_edge got dn=%b cr=%b want 1 0", load_done, cpu_reset);
    end
    idle(3);
    checks++;
    if (wa.size() != 10) begin
      errors++;
      $display("FAIL prog_write_count got %0d want 10", wa.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wa[i] !== 5'(i) || wd[i] !== ed[i]) begin
          errors++;
          $display("FAIL prog_write%0d got %h:%h want %h:%h", i, wa[i], wd[i], 5'(i), ed[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || load_err !== 1'b0 || cpu_reset !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL prog_status got done=%0d er=%b cr=%b dn=%b want 1 0 0 0", done_cnt, load_err, cpu_reset, load_done);
    end
  endtask

  task automatic test_load_vars();
    byte_q_t f;
    clear_mon();
    f = '{8'h00, 8'hFF, 8'h3C};
    send_seq(f);
    idle(2);
    checks++;
    if (wa.size() != 0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL junk_ignored got writes=%0d cr=%b want 0 0", wa.size(), cpu_reset);
    end
    f = '{8'hA5, 8'h11, 8'h02, 8'h05, 8'h01, 8'h19};
    send_seq(f);
    idle(2);
    checks++;
    if (wa.size() != 2 || wa[0] !== 5'h11 || wd[0] !== 8'h05 || wa[1] !== 5'h12 || wd[1] !== 8'h01) begin
      errors++;
      $display("FAIL vars_writes got n=%0d first=%h:%h want 2 writes 11:05 12:01", wa.size(), wa[0], wd[0]);
    end
    checks++;
    if (done_cnt != 1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL vars_done got done=%0d cr=%b want 1 0", done_cnt, cpu_reset);
    end
  endtask

  task automatic test_wrap();
    byte_q_t f;
    clear_mon();
    f = '{8'hA5, 8'h1E, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h52};
    send_seq(f);
    idle(2);
    checks++;
    if (wa.size() != 3 || wa[0] !== 5'h1E || wa[1] !== 5'h1F || wa[2] !== 5'h00
        || wd[0] !== 8'hAA || wd[1] !== 8'hBB || wd[2] !== 8'hCC) begin
      errors++;
      $display("FAIL wrap_writes got n=%0d last=%h:%h want 1E:AA 1F:BB 00:CC", wa.size(), wa[wa.size()-1], wd[wd.size()-1]);
    end
    checks++;
    if (done_cnt != 1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done got done=%0d er=%b want 1 0", done_cnt, load_err);
    end
  endtask

  task automatic test_bad_csum();
    byte_q_t f;
    clear_mon();
    f = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h00};
    send_seq(f);
    idle(2);
    checks++;
    if (wa.size() != 1 || wa[0] !== 5'h00 || wd[0] !== 8'h77) begin
      errors++;
      $display("FAIL bad_write got n=%0d want one write 00:77", wa.size());
    end
    checks++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL bad_status got er=%b cr=%b done=%0d want 1 1 0", load_err, cpu_reset, done_cnt);
    end
    send(8'hA5);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_at_sync got %b want 0", load_err);
    end
    f = '{8'h11, 8'h02, 8'h05, 8'h01, 8'h19};
    send_seq(f);
    idle(2);
    checks++;
    if (done_cnt != 1 || cpu_reset !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL recover_done got done=%0d cr=%b er=%b want 1 0 0", done_cnt, cpu_reset, load_err);
    end
  endtask

  task automatic test_timeout();
    byte_q_t f;
    clear_mon();
    f = '{8'hA5, 8'h00, 8'h02, 8'h11};
    send_seq(f);
    idle(63);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got er=%b after 63 idle want 0", load_err);
    end
    idle(1);
    checks++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit got er=%b cr=%b want 1 1", load_err, cpu_reset);
    end
    send(8'h22);
    idle(2);
    checks++;
    if (wa.size() != 1 || wd[0] !== 8'h11 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_discard got writes=%0d done=%0d want 1 0", wa.size(), done_cnt);
    end
  endtask

  task automatic test_gaps();
    byte_q_t f;
    int gaps[7] = '{3, 0, 63, 1, 17, 5, 2};
    clear_mon();
    f = '{8'hA5, 8'h1E, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h52};
    foreach (f[i]) begin
      send(f[i]);
      if (gaps[i] > 0) idle(gaps[i]);
    end
    idle(2);
    checks++;
    if (wa.size() != 3 || wa[2] !== 5'h00 || wd[2] !== 8'hCC || done_cnt != 1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_frame got writes=%0d done=%0d er=%b want 3 1 0", wa.size(), done_cnt, load_err);
    end
  endtask

  task automatic test_reset_midframe();
    byte_q_t f;
    f = '{8'hA5, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h99};
    send_seq(f);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err, bus.in_ready} !== {1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got we=%b a=%h d=%h cr=%b dn=%b er=%b rdy=%b want 0 00 00 1 0 0 0",
               mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err, bus.in_ready);
    end
    clear_mon();
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wa.size() != 0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL no_write_in_reset got writes=%0d we=%b want 0 0", wa.size(), mem_we);
    end
    do_reset();
    clear_mon();
    f = '{8'hA5, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h99, 8'h53, 8'h13, 8'hD9, 8'h99, 8'h53, 8'hC4, 8'hC9, 8'h8E};
    send_seq(f);
    idle(2);
    checks++;
    if (wa.size() != 10 || done_cnt != 1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_reset got writes=%0d done=%0d cr=%b want 10 1 0", wa.size(), done_cnt, cpu_reset);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    done_cnt = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_load_program();
    test_load_vars();
    test_wrap();
    test_bad_csum();
    test_timeout();
    test_gaps();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
